// File: rtl/sfixed_mult_arbiter.sv
// Round-robin sharing of one signed fixed-point multiplier between NUM_REQ requesters,
// with a single registered result port tagged by requester index.

module sfixed_mult #(
  parameter int A_LEFT    = 3,
  parameter int A_RIGHT   = 4,
  parameter int B_LEFT    = 3,
  parameter int B_RIGHT   = 4,
  parameter int OUT_LEFT  = 7,
  parameter int OUT_RIGHT = 8,
  localparam int AW = A_LEFT + A_RIGHT + 1,
  localparam int BW = B_LEFT + B_RIGHT + 1,
  localparam int OW = OUT_LEFT + OUT_RIGHT + 1
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [OW-1:0] p
);
  localparam int PW   = AW + BW;
  localparam int FRAC = A_RIGHT + B_RIGHT;
  localparam int HI   = FRAC + OUT_LEFT;
  localparam int LO   = FRAC - OUT_RIGHT;

  logic signed [PW-1:0] full;

  // Size casts of signed operands sign-extend, so the product is full precision.
  assign full = PW'(a) * PW'(b);

  generate
    if (HI > PW - 1 || LO < 0) begin : g_bad_slice
      $error("sfixed_mult: output slice [%0d:%0d] outside product [%0d:0]", HI, LO, PW - 1);
      assign p = '0;
    end else begin : g_slice
      assign p = full[HI:LO];
    end
  endgenerate
endmodule

module sfixed_mult_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int A_LEFT    = 3,
  parameter int A_RIGHT   = 4,
  parameter int B_LEFT    = 3,
  parameter int B_RIGHT   = 4,
  parameter int OUT_LEFT  = 7,
  parameter int OUT_RIGHT = 8,
  localparam int ID_W = $clog2(NUM_REQ),
  localparam int AW   = A_LEFT + A_RIGHT + 1,
  localparam int BW   = B_LEFT + B_RIGHT + 1,
  localparam int OW   = OUT_LEFT + OUT_RIGHT + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_a,
  input  logic [NUM_REQ*BW-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OW-1:0]         res_data,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy
);
  // Handshake: a request transfers when req_valid[i] && req_ready[i]; the result
  // transfers when res_valid && res_ready. Requesters hold valid/a/b until accepted.

  generate
    if (NUM_REQ < 2) begin : g_bad_num_req
      $error("sfixed_mult_arbiter: NUM_REQ must be >= 2");
    end
  endgenerate

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      cand;
  logic                 grant_found;
  logic                 can_issue;
  logic                 transfer;
  int                   idx;
  logic signed [AW-1:0] mult_a;
  logic signed [BW-1:0] mult_b;
  logic signed [OW-1:0] mult_p;

  assign can_issue = !res_valid || res_ready;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the modulo keeps non-power-of-2 in range.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign transfer = grant_found && can_issue && !rst;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  assign mult_a = req_a[int'(grant_idx)*AW +: AW];
  assign mult_b = req_b[int'(grant_idx)*BW +: BW];

  sfixed_mult #(
    .A_LEFT   (A_LEFT),
    .A_RIGHT  (A_RIGHT),
    .B_LEFT   (B_LEFT),
    .B_RIGHT  (B_RIGHT),
    .OUT_LEFT (OUT_LEFT),
    .OUT_RIGHT(OUT_RIGHT)
  ) u_mult (
    .a(mult_a),
    .b(mult_b),
    .p(mult_p)
  );

  // A new transfer overwrites a draining result in the same cycle, so no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      res_valid <= 1'b1;
      res_data  <= mult_p;
      res_id    <= grant_idx;
      rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign busy = res_valid || (|req_valid);
endmodule

// File: doc/sfixed_mult_arbiter.md
Name: sfixed_mult_arbiter

Overview:
- Shares one signed fixed-point multiplier (`sfixed_mult`, instantiated internally) between NUM_REQ requesters.
- Each requester has a valid/ready operand port. A round-robin arbiter grants one request per cycle.
- The product is registered on a single result port tagged with the requester index, with downstream backpressure.
- Sits between the compute lanes of the core and the single multiplier instance, so the multiplier is not replicated per lane.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- ID_W, $clog2(NUM_REQ), width of the result tag (derived; do not override).
- A_LEFT, 3, integer bits of operand a, excluding sign.
- A_RIGHT, 4, fraction bits of operand a.
- B_LEFT, 3, integer bits of operand b, excluding sign.
- B_RIGHT, 4, fraction bits of operand b.
- OUT_LEFT, 7, integer bits of the result, excluding sign.
- OUT_RIGHT, 8, fraction bits of the result.
- Widths: AW=A_LEFT+A_RIGHT+1, BW=B_LEFT+B_RIGHT+1, OW=OUT_LEFT+OUT_RIGHT+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*AW  flattened signed a operands; requester i occupies [i*AW +: AW].
- req_b  in  NUM_REQ*BW  flattened signed b operands; requester i occupies [i*BW +: BW].
- res_valid  out  1  result register holds a valid product.
- res_ready  in  1  downstream accepts the result.
- res_data  out  OW  signed product in Q(OUT_LEFT).(OUT_RIGHT) format.
- res_id  out  ID_W  index of the requester that produced res_data.
- busy  out  1  res_valid OR any req_valid (registered-output plus pending-demand indicator).

Behaviour:
- Reset (rst=1 at an edge): res_valid=0, res_data=0, res_id=0, rr_ptr=0.
  - req_ready is all zeros while rst is high, regardless of other inputs.
  - Reset aborts any held result; it is dropped, not delivered.
- can_issue = !res_valid || res_ready. This is a combinational pass-through, giving full throughput of one product per cycle.
- Arbitration (combinational):
  - When can_issue=1, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[grant]=1; all other bits are 0.
  - When can_issue=0 or no request is valid, req_ready=0.
  - req_ready may depend combinationally on req_valid and res_ready.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester must hold valid, a and b stable until it is accepted. Valid must not drop before acceptance; the arbiter does not check this.
- Pointer update: on a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
  - Wrap: a grant to NUM_REQ-1 sets rr_ptr=0.
  - Non-power-of-2 NUM_REQ must wrap correctly and never grant an out-of-range index.
- Result register:
  - On a transfer: res_data <= product of the granted operands, res_id <= i, res_valid <= 1. Latency is exactly 1 cycle from the accept edge to res_valid.
  - Else, if res_valid && res_ready: res_valid <= 0; res_data and res_id hold their stale values.
  - Else: hold.
  - Simultaneous drain and transfer in the same cycle: the new result replaces the old; res_valid stays 1, with no bubble.
- Arithmetic:
  - Full product width P = AW+BW, with A_RIGHT+B_RIGHT fraction bits.
  - res_data = product bits [(A_RIGHT+B_RIGHT)+OUT_LEFT : (A_RIGHT+B_RIGHT)-OUT_RIGHT].
  - Plain truncation: no rounding, no saturation; overflow wraps.
  - The slice must lie within [P-1:0]; enforce this with an elaboration-time check.
- Fairness:
  - Under continuous demand from all requesters and res_ready=1, the grant sequence is 0,1,2,…,NUM_REQ-1,0,…
  - No requester waits more than NUM_REQ-1 grants.
- Backpressure: while res_valid=1 and res_ready=0, no request is accepted and rr_ptr is frozen.

Test Plan:
- Reset, then req_valid[1]=1, a=0x18 (1.5), b=0x24 (2.25), res_ready=1:
  - req_ready=4'b0010 in that cycle.
  - Next cycle: res_valid=1, res_data=0x0360 (3.375), res_id=1.
- Signed operands: a=0xF0 (-1.0), b=0x18 → res_data=0xFE80 (-1.5).
- Corner: a=b=0x80 (-8.0) → res_data=0x4000 (64.0).
- All four req_valid held high, res_ready=1, for 8 cycles:
  - Grants 0,1,2,3,0,1,2,3.
  - res_id follows the same sequence one cycle later.
  - req_ready is one-hot every cycle.
- Result pending, res_ready=0 for 3 cycles while req_valid=4'b1111:
  - req_ready=0, and res_data/res_id stay stable.
  - When res_ready rises, the next grant goes to the index after the last one granted, and the new result appears the following cycle without a bubble.
- Assert rst for one cycle while res_valid=1 and requests are pending:
  - Next cycle: res_valid=0, res_data=0, res_id=0.
  - The first post-reset grant goes to the lowest valid index ≥0.
- NUM_REQ=3, only requester 2 valid, then requesters 0 and 2 valid:
  - After granting 2, rr_ptr wraps to 0, and 0 is granted before 2.
